shift_register_universal_n: RTL and testbench

Parametrised N-bit universal shift register, the successor to the 4-bit bidirectional register. Adds logical and arithmetic shifts, rotates, parallel load and serial in/out. A START/AMT command engine performs multi-bit shifts, one bit per clock, with BUSY/DONE handshake. Used by datapath blocks that need a serial converter or a slow barrel shift without a full combinational shifter.

---
 rtl/shift_reg_pkg.sv | 37 +++
 rtl/shift_register_universal_n_if.sv | 30 +++
 rtl/shift_reg_step.sv | 37 +++
 rtl/shift_register_universal_n.sv | 141 ++++++++++++++
 tb/tb_shift_register_universal_n.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: mode encoding, FSM states
// and small mode-classification helpers used by the top and the step logic.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_SLL    = 3'b001,
        MODE_SRL    = 3'b010,
        MODE_ROL    = 3'b011,
        MODE_ROR    = 3'b100,
        MODE_SRA    = 3'b101,
        MODE_LOAD   = 3'b110,
        MODE_HOLD_R = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Modes that run as a counted multi-step burst.
    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SLL) || (m == MODE_SRL) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_SRA);
    endfunction

    // Steps that move a bit out of the MSB (update SOL).
    function automatic logic is_left_mode(input mode_e m);
        return (m == MODE_SLL) || (m == MODE_ROL);
    endfunction

    // Steps that move a bit out of the LSB (update SOR).
    function automatic logic is_right_mode(input mode_e m);
        return (m == MODE_SRL) || (m == MODE_ROR) || (m == MODE_SRA);
    endfunction

endpackage

// File: rtl/shift_register_universal_n_if.sv
// Command/data bundle of the universal shift register.
//   master: drives start/mode/amt/d/sil/sir, observes q/sol/sor/busy/done
//   slave : the register itself
interface shift_register_universal_n_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sir;
    logic [WIDTH-1:0] q;
    logic             sol;
    logic             sor;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amt, d, sil, sir,
        input  q, sol, sor, busy, done
    );

    modport slave (
        input  start, mode, amt, d, sil, sir,
        output q, sol, sor, busy, done
    );
endinterface

// File: rtl/shift_reg_step.sv
// Single-bit step of the universal shift register (purely combinational).
//   q       : current register value
//   mode    : step function (non-shift modes pass q through)
//   sil/sir : serial inputs for SLL (enters bit 0) / SRL (enters MSB)
//   q_next  : register value after one step
//   shout_l : bit leaving the MSB on a left step
//   shout_r : bit leaving the LSB on a right step
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q_next,
    output logic             shout_l,
    output logic             shout_r
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_SLL: q_next = {q[WIDTH-2:0], sil};
            MODE_SRL: q_next = {sir, q[WIDTH-1:1]};
            MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
            MODE_SRA: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  q_next = q;
        endcase
    end

    assign shout_l = q[WIDTH-1];
    assign shout_r = q[0];

endmodule

// File: rtl/shift_register_universal_n.sv
// N-bit universal shift register with a START/AMT command engine that
// performs multi-bit shifts and rotates one bit per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.start  : command strobe, ignored while busy
//   bus.mode   : hold / SLL / SRL / ROL / ROR / SRA / load / hold
//   bus.amt    : number of single-bit steps (0..WIDTH)
//   bus.d      : parallel load data
//   bus.sil/sir: serial inputs, sampled live on each step edge
//   bus.q      : register contents
//   bus.sol/sor: last bit shifted out of MSB / LSB
//   bus.busy   : burst in progress
//   bus.done   : one-cycle pulse on command completion
module shift_register_universal_n
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shift_register_universal_n_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sol_q, sol_d;
    logic             sor_q, sor_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    mode_e            cmd_mode;
    logic             cmd_burst;
    logic             last_step;
    logic [WIDTH-1:0] step_q;
    logic             step_sol;
    logic             step_sor;

    assign cmd_mode  = mode_e'(bus.mode);
    assign cmd_burst = is_shift_mode(cmd_mode) && (bus.amt != '0);
    assign last_step = (cnt_q == CNT_W'(1));

    // The step function always works on the mode latched at START.
    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_q),
        .mode    (mode_q),
        .sil     (bus.sil),
        .sir     (bus.sir),
        .q_next  (step_q),
        .shout_l (step_sol),
        .shout_r (step_sor)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start && cmd_burst) state_d = ST_SHIFT;
            ST_SHIFT: if (last_step)              state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and handshake next values.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        sol_d  = sol_q;
        sor_d  = sor_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cmd_mode == MODE_LOAD) begin
                        q_d    = bus.d;
                        done_d = 1'b1;
                    end else if (cmd_burst) begin
                        mode_d = cmd_mode;
                        cnt_d  = bus.amt;
                        busy_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (is_left_mode(mode_q))  sol_d = step_sol;
                if (is_right_mode(mode_q)) sor_d = step_sor;
                // Busy drops on the same edge that raises done.
                done_d = last_step;
                busy_d = !last_step;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_HOLD;
            cnt_q  <= '0;
            q_q    <= '0;
            sol_q  <= 1'b0;
            sor_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            sol_q  <= sol_d;
            sor_q  <= sor_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sol  = sol_q;
    assign bus.sor  = sor_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_register_universal_n.sv
// Directed bench for shift_register_universal_n at WIDTH=8: a command table
// plus hand-written sequences for mid-burst START, live serial input and
// reset during a burst.
module tb_shift_register_universal_n;

    localparam int unsigned W = 8;
    localparam logic [2:0] M_HOLD   = 3'b000;
    localparam logic [2:0] M_SLL    = 3'b001;
    localparam logic [2:0] M_SRL    = 3'b010;
    localparam logic [2:0] M_ROL    = 3'b011;
    localparam logic [2:0] M_ROR    = 3'b100;
    localparam logic [2:0] M_SRA    = 3'b101;
    localparam logic [2:0] M_LOAD   = 3'b110;
    localparam logic [2:0] M_HOLD_R = 3'b111;

    typedef struct {
        logic [2:0] mode;
        logic [3:0] amt;
        logic [7:0] d;
        logic       sil;
        logic       sir;
        logic [7:0] exp_q;
        logic       exp_sol;
        logic       exp_sor;
        int         exp_cyc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    bit   excl_en;

    shift_register_universal_n_if #(.WIDTH(W)) bus ();

    shift_register_universal_n #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (excl_en && rst_n) chk("busy_done_excl", 32'(bus.busy && bus.done), 32'd0);
    end

    // Issue one command; return at the negedge where done is seen.
    task automatic run_cmd(input logic [2:0] mode, input logic [3:0] amt, input logic [7:0] d,
                           input logic sil, input logic sir,
                           output int busy_cyc, output bit got_done);
        busy_cyc = 0;
        got_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = mode;
        bus.amt   = amt;
        bus.d     = d;
        bus.sil   = sil;
        bus.sir   = sir;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[15];

    initial begin
        int  cyc;
        bit  gd;
        int  dones;

        n_assert  = 0;
        n_fail    = 0;
        excl_en   = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = M_HOLD;
        bus.amt   = '0;
        bus.d     = '0;
        bus.sil   = 1'b0;
        bus.sir   = 1'b0;

        //           mode      amt   d      sil   sir   q      sol   sor   cyc
        vecs[0]  = '{M_LOAD,   4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0};
        vecs[1]  = '{M_ROL,    4'd3, 8'h00, 1'b0, 1'b0, 8'h2D, 1'b1, 1'b0, 3};
        vecs[2]  = '{M_LOAD,   4'd0, 8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, 0};
        vecs[3]  = '{M_SRA,    4'd2, 8'h00, 1'b0, 1'b0, 8'hE5, 1'b1, 1'b1, 2};
        vecs[4]  = '{M_LOAD,   4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0};
        vecs[5]  = '{M_SLL,    4'd8, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8};
        vecs[6]  = '{M_ROR,    4'd0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0};
        vecs[7]  = '{M_HOLD_R, 4'd5, 8'h12, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0};
        vecs[8]  = '{M_HOLD,   4'd3, 8'h34, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0};
        vecs[9]  = '{M_SRL,    4'd4, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 4};
        vecs[10] = '{M_ROR,    4'd8, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 8};
        vecs[11] = '{M_ROL,    4'd8, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 8};
        vecs[12] = '{M_SRL,    4'd8, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8};
        vecs[13] = '{M_LOAD,   4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
        vecs[14] = '{M_SLL,    4'd1, 8'h00, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0, 1};

        // Reset state.
        #12;
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_sol", 32'(bus.sol), 32'd0);
        chk("rst_sor", 32'(bus.sor), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        excl_en = 1'b1;

        // Command table.
        for (int i = 0; i < 15; i++) begin
            run_cmd(vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].sil, vecs[i].sir, cyc, gd);
            chk($sformatf("v%0d_done", i), 32'(gd), 32'd1);
            chk($sformatf("v%0d_busycyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_q", i), 32'(bus.q), 32'(vecs[i].exp_q));
            chk($sformatf("v%0d_sol", i), 32'(bus.sol), 32'(vecs[i].exp_sol));
            chk($sformatf("v%0d_sor", i), 32'(bus.sor), 32'(vecs[i].exp_sor));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // START during a burst is ignored; intermediate SRA value visible.
        run_cmd(M_LOAD, 4'd0, 8'h96, 1'b0, 1'b0, cyc, gd);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = M_SRA; bus.amt = 4'd2;
        @(negedge clk);
        bus.mode = M_LOAD; bus.d = 8'h00; bus.amt = 4'd0;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_q_step1", 32'(bus.q), 32'hCB);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        chk("mid_done_count", 32'(dones), 32'd1);
        chk("mid_q_final", 32'(bus.q), 32'hE5);
        chk("mid_sor", 32'(bus.sor), 32'd1);

        // SLL x8 with SIL=1 held: all-ones fill, sol stays 0.
        run_cmd(M_LOAD, 4'd0, 8'h00, 1'b0, 1'b0, cyc, gd);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = M_SLL; bus.amt = 4'd8; bus.sil = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            chk($sformatf("sll1_q%0d", s), 32'(bus.q), 32'((9'd1 << (s + 1)) - 9'd1));
            chk($sformatf("sll1_sol%0d", s), 32'(bus.sol), 32'd0);
        end
        chk("sll1_done", 32'(bus.done), 32'd1);

        // SLL x8 with SIL toggling 1,0,... sampled live on each step.
        run_cmd(M_LOAD, 4'd0, 8'h00, 1'b0, 1'b0, cyc, gd);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = M_SLL; bus.amt = 4'd8; bus.sil = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            bus.sil = (s % 2 == 0);
            @(negedge clk);
        end
        chk("sll_tog_done", 32'(bus.done), 32'd1);
        chk("sll_tog_q", 32'(bus.q), 32'hAA);

        // Asynchronous reset two steps into an ROR x6 burst.
        run_cmd(M_LOAD, 4'd0, 8'hF0, 1'b0, 1'b0, cyc, gd);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = M_ROR; bus.amt = 4'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rr_q1", 32'(bus.q), 32'h78);
        @(negedge clk);
        chk("rr_q2", 32'(bus.q), 32'h3C);
        chk("rr_busy_pre", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_q", 32'(bus.q), 32'h00);
        chk("rr_busy", 32'(bus.busy), 32'd0);
        chk("rr_done", 32'(bus.done), 32'd0);
        chk("rr_sor", 32'(bus.sor), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("rr_no_activity", 32'(dones), 32'd0);
        run_cmd(M_LOAD, 4'd0, 8'h11, 1'b0, 1'b0, cyc, gd);
        chk("rr_idle_done", 32'(gd), 32'd1);
        chk("rr_idle_cyc", 32'(cyc), 32'd0);
        chk("rr_idle_q", 32'(bus.q), 32'h11);

        @(negedge clk);
        excl_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
